// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared FSM states, forwarding encodings and forwarding helper
//               for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    // The younger producer (M) wins over W; x0 is hard-wired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Bundle between the pipeline datapath (master) and the hazard
//               controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_addr_D;
    logic [4:0]       rs2_addr_D;
    logic [4:0]       rs1_addr_E;
    logic [4:0]       rs2_addr_E;
    logic [4:0]       rd_addr_E;
    logic [4:0]       rd_addr_M;
    logic [4:0]       rd_addr_W;
    logic             reg_wr_en_E;
    logic             reg_wr_en_M;
    logic             reg_wr_en_W;
    logic             is_load_E;
    logic             br_taken_E;
    logic             mem_req_M;
    logic             mem_ack;

    logic             pc_en;
    logic             en_FD;
    logic             en_DE;
    logic             en_EM;
    logic             en_MW;
    logic             flush_FD;
    logic             flush_DE;
    logic             flush_EM;
    logic             flush_MW;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_err;

    modport slave (
        input  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
        input  rd_addr_E, rd_addr_M, rd_addr_W,
        input  reg_wr_en_E, reg_wr_en_M, reg_wr_en_W,
        input  is_load_E, br_taken_E, mem_req_M, mem_ack,
        output pc_en, en_FD, en_DE, en_EM, en_MW,
        output flush_FD, flush_DE, flush_EM, flush_MW,
        output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, mem_err
    );

    modport master (
        output rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
        output rd_addr_E, rd_addr_M, rd_addr_W,
        output reg_wr_en_E, reg_wr_en_M, reg_wr_en_W,
        output is_load_E, br_taken_E, mem_req_M, mem_ack,
        input  pc_en, en_FD, en_DE, en_EM, en_MW,
        input  flush_FD, flush_DE, flush_EM, flush_MW,
        input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt, mem_err
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : 5-stage pipeline stall/flush/forward control with data-memory
//               wait handling, timeout error and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int                  c_WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                w_freeze;
    logic                w_active;
    logic                w_hazard_ok;
    logic                w_load_use;
    logic                w_branch;
    logic                w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // r_wait_cnt holds the number of ack-less MEM_WAIT cycles already spent.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_freeze    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.mem_req_M && !bus.mem_ack) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_freeze = 1'b1;
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
                    end
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    assign w_active    = rst_n && (r_state != ST_ERR);
    assign w_hazard_ok = w_active && !w_freeze;
    assign w_load_use  = bus.is_load_E && bus.reg_wr_en_E && (bus.rd_addr_E != 5'd0) &&
                         ((bus.rd_addr_E == bus.rs1_addr_D) || (bus.rd_addr_E == bus.rs2_addr_D));
    assign w_branch    = w_hazard_ok && bus.br_taken_E;
    assign w_stall     = w_hazard_ok && !bus.br_taken_E && w_load_use;

    always_comb begin
        bus.pc_en    = 1'b1;
        bus.en_FD    = 1'b1;
        bus.en_DE    = 1'b1;
        bus.en_EM    = 1'b1;
        bus.en_MW    = 1'b1;
        bus.flush_FD = 1'b0;
        bus.flush_DE = 1'b0;
        bus.flush_EM = 1'b0;
        bus.flush_MW = 1'b0;
        if (!rst_n) begin
            bus.pc_en    = 1'b0;
            bus.en_FD    = 1'b0;
            bus.en_DE    = 1'b0;
            bus.en_EM    = 1'b0;
            bus.en_MW    = 1'b0;
            bus.flush_FD = 1'b1;
            bus.flush_DE = 1'b1;
            bus.flush_EM = 1'b1;
            bus.flush_MW = 1'b1;
        end else if (r_state == ST_ERR) begin
            bus.pc_en = 1'b0;
            bus.en_FD = 1'b0;
            bus.en_DE = 1'b0;
            bus.en_EM = 1'b0;
            bus.en_MW = 1'b0;
        end else if (w_freeze) begin
            // M keeps its access; W takes a bubble so it does not write back twice.
            bus.pc_en    = 1'b0;
            bus.en_FD    = 1'b0;
            bus.en_DE    = 1'b0;
            bus.en_EM    = 1'b0;
            bus.flush_MW = 1'b1;
        end else if (w_branch) begin
            bus.flush_FD = 1'b1;
            bus.flush_DE = 1'b1;
        end else if (w_stall) begin
            bus.pc_en    = 1'b0;
            bus.en_FD    = 1'b0;
            bus.flush_DE = 1'b1;
        end
    end

    always_comb begin
        bus.fwd_a_sel = FWD_RF;
        bus.fwd_b_sel = FWD_RF;
        if (rst_n) begin
            bus.fwd_a_sel = fwd_sel(bus.rs1_addr_E, bus.reg_wr_en_M, bus.rd_addr_M,
                                    bus.reg_wr_en_W, bus.rd_addr_W);
            bus.fwd_b_sel = fwd_sel(bus.rs2_addr_E, bus.reg_wr_en_M, bus.rd_addr_M,
                                    bus.reg_wr_en_W, bus.rd_addr_W);
        end
    end

    assign bus.mem_err = (r_state == ST_ERR);

    sat_cnt #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((w_active && w_freeze) || w_stall),
        .count (bus.stall_cnt)
    );

    sat_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_branch),
        .count (bus.flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and randomized checks of pipe_hazard_ctrl against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = error.
    int m_mode   = 0;
    int m_waited = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.rs1_addr_D  = 5'd0;
        bus.rs2_addr_D  = 5'd0;
        bus.rs1_addr_E  = 5'd0;
        bus.rs2_addr_E  = 5'd0;
        bus.rd_addr_E   = 5'd0;
        bus.rd_addr_M   = 5'd0;
        bus.rd_addr_W   = 5'd0;
        bus.reg_wr_en_E = 1'b0;
        bus.reg_wr_en_M = 1'b0;
        bus.reg_wr_en_W = 1'b0;
        bus.is_load_E   = 1'b0;
        bus.br_taken_E  = 1'b0;
        bus.mem_req_M   = 1'b0;
        bus.mem_ack     = 1'b0;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (bus.reg_wr_en_M && bus.rd_addr_M == rs) return 2'b01;
        if (bus.reg_wr_en_W && bus.rd_addr_W == rs) return 2'b10;
        return 2'b00;
    endfunction

    // Called just after a falling edge with the cycle's inputs applied.
    task automatic step();
        bit         frozen, branch, lu, cond_lu;
        logic       e_pc;
        logic [3:0] e_en, e_fl, a_en, a_fl;
        logic [1:0] e_fa, e_fb;
        #2;
        if (!rst_n) begin
            m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        end
        cond_lu = bus.is_load_E && bus.reg_wr_en_E && bus.rd_addr_E != 5'd0 &&
                  (bus.rd_addr_E == bus.rs1_addr_D || bus.rd_addr_E == bus.rs2_addr_D);
        frozen = rst_n && ((m_mode == 0 && bus.mem_req_M && !bus.mem_ack) ||
                           (m_mode == 1 && !bus.mem_ack));
        branch = rst_n && m_mode != 2 && !frozen && bus.br_taken_E;
        lu     = rst_n && m_mode != 2 && !frozen && !bus.br_taken_E && cond_lu;
        if (!rst_n)           begin e_pc = 0; e_en = 4'b0000; e_fl = 4'b1111; end
        else if (m_mode == 2) begin e_pc = 0; e_en = 4'b0000; e_fl = 4'b0000; end
        else if (frozen)      begin e_pc = 0; e_en = 4'b0001; e_fl = 4'b0001; end
        else if (branch)      begin e_pc = 1; e_en = 4'b1111; e_fl = 4'b1100; end
        else if (lu)          begin e_pc = 0; e_en = 4'b0111; e_fl = 4'b0100; end
        else                  begin e_pc = 1; e_en = 4'b1111; e_fl = 4'b0000; end
        e_fa = rst_n ? fwd_ref(bus.rs1_addr_E) : 2'b00;
        e_fb = rst_n ? fwd_ref(bus.rs2_addr_E) : 2'b00;
        a_en = {bus.en_FD, bus.en_DE, bus.en_EM, bus.en_MW};
        a_fl = {bus.flush_FD, bus.flush_DE, bus.flush_EM, bus.flush_MW};
        chk("pc_en", 32'(bus.pc_en), 32'(e_pc));
        chk("en_FD_DE_EM_MW", 32'(a_en), 32'(e_en));
        chk("flush_FD_DE_EM_MW", 32'(a_fl), 32'(e_fl));
        chk("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(e_fa));
        chk("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(e_fb));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
        chk("mem_err", 32'(bus.mem_err), 32'(m_mode == 2));
        @(posedge clk);
        if (rst_n) begin
            if ((frozen || lu) && m_stall < CMAX) m_stall++;
            if (branch && m_flush < CMAX) m_flush++;
            if (m_mode == 0) begin
                if (bus.mem_req_M && !bus.mem_ack) begin m_mode = 1; m_waited = 0; end
            end else if (m_mode == 1) begin
                if (bus.mem_ack) m_mode = 0;
                else begin
                    m_waited++;
                    if (m_waited == TMO) m_mode = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        chk("reset_flush_all", 32'({bus.flush_FD, bus.flush_DE, bus.flush_EM, bus.flush_MW}), 32'hF);
        rst_n = 1'b1;
        step();

        // Load-use on rs2
        bus.is_load_E = 1; bus.reg_wr_en_E = 1; bus.rd_addr_E = 5'd5; bus.rs2_addr_D = 5'd5;
        step();
        chk("loaduse_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        // Branch overriding the same load-use
        bus.br_taken_E = 1;
        step();
        chk("branch_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("branch_stall_cnt_held", 32'(bus.stall_cnt), 32'd1);

        // Forwarding
        clear_inputs();
        bus.rd_addr_M = 5'd7; bus.rd_addr_W = 5'd7; bus.reg_wr_en_M = 1; bus.reg_wr_en_W = 1;
        bus.rs1_addr_E = 5'd7;
        #2 chk("fwd_m_priority", 32'(bus.fwd_a_sel), 32'd1);
        bus.reg_wr_en_M = 0;
        #2 chk("fwd_w_only", 32'(bus.fwd_a_sel), 32'd2);
        bus.rd_addr_M = 5'd0; bus.rd_addr_W = 5'd0; bus.reg_wr_en_M = 1; bus.rs1_addr_E = 5'd0;
        #2 chk("fwd_x0", 32'(bus.fwd_a_sel), 32'd0);
        @(negedge clk);
        step();

        // Memory wait: three frozen cycles then release
        clear_inputs();
        bus.mem_req_M = 1;
        repeat (3) step();
        bus.mem_ack = 1;
        step();
        clear_inputs();
        #2 chk("release_pc_en", 32'(bus.pc_en), 32'd1);
        @(negedge clk);
        step();

        // Timeout into ERR, then reset recovery
        bus.mem_req_M = 1;
        repeat (1 + TMO) step();
        chk("timeout_mem_err", 32'(bus.mem_err), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        chk("reset_clears_err", 32'(bus.mem_err), 32'd0);
        rst_n = 1'b1;
        clear_inputs();
        step();

        // Stall counter saturation
        bus.is_load_E = 1; bus.reg_wr_en_E = 1; bus.rd_addr_E = 5'd3; bus.rs1_addr_D = 5'd3;
        repeat (CMAX + 2) step();
        chk("stall_cnt_saturated", 32'(bus.stall_cnt), 32'(CMAX));

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst_n           = ($urandom_range(0, 99) >= 2);
            bus.rs1_addr_D  = 5'($urandom_range(0, 7));
            bus.rs2_addr_D  = 5'($urandom_range(0, 7));
            bus.rs1_addr_E  = 5'($urandom_range(0, 7));
            bus.rs2_addr_E  = 5'($urandom_range(0, 7));
            bus.rd_addr_E   = 5'($urandom_range(0, 7));
            bus.rd_addr_M   = 5'($urandom_range(0, 7));
            bus.rd_addr_W   = 5'($urandom_range(0, 7));
            bus.reg_wr_en_E = 1'($urandom_range(0, 1));
            bus.reg_wr_en_M = 1'($urandom_range(0, 1));
            bus.reg_wr_en_W = 1'($urandom_range(0, 1));
            bus.is_load_E   = ($urandom_range(0, 99) < 40);
            bus.br_taken_E  = ($urandom_range(0, 99) < 15);
            bus.mem_req_M   = ($urandom_range(0, 99) < 30);
            bus.mem_ack     = ($urandom_range(0, 99) < 60);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
